// File: rtl/zigzag_block_buffer_if.sv
// Handshake bundle for the zigzag block buffer.
// The input side carries one beat of eight coefficients.
// The output side carries one raster-ordered 8x8 block.
interface zigzag_block_buffer_if #(
   parameter int COEF_W = 8
);
   logic                  in_valid;
   logic [8*COEF_W-1:0]   in_data;
   logic                  in_ready;
   logic                  out_valid;
   logic                  out_ready;
   logic [64*COEF_W-1:0]  out_block;

   // Upstream/downstream side: drives beats and accepts blocks.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_block
   );

   // Buffer side.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_block
   );
endinterface

// File: rtl/zigzag_block_buffer.sv
// Zigzag-to-raster block buffer.
// Eight zigzag-ordered coefficients arrive per beat. They are scattered into
// raster positions of a ping-pong bank pair. A bank is offered downstream as a
// whole 8x8 block once all eight beats have landed. The output is driven from
// registers only, so there is no combinational path from in_* to out_*.
module zigzag_block_buffer #(
   parameter int COEF_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   zigzag_block_buffer_if.slave bus_io
);

   // Zigzag index z -> raster position 8*row+col.
   localparam logic [5:0] ZZ [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   logic [2:0]        beat_q, beat_d;   // beat index within the filling block
   logic              wp_q, wp_d;       // bank being filled
   logic              rp_q, rp_d;       // bank being presented
   logic [1:0]        full_q, full_d;   // per-bank "complete block" flag
   logic [COEF_W-1:0] bank_q [2][64];   // raster-ordered storage

   logic in_fire;
   logic out_fire;

   assign in_fire          = bus_io.in_valid  & ~full_q[wp_q];
   assign out_fire         = bus_io.out_ready &  full_q[rp_q];
   assign bus_io.in_ready  = ~full_q[wp_q];
   assign bus_io.out_valid =  full_q[rp_q];

   // Next-state for pointers, beat counter and FULL flags.
   // A pop and a completion can land on the same edge; they always target
   // different banks because a full bank blocks input and an empty one blocks output.
   always_comb begin
      // NOTE: every variable gets a default first so no latch is inferred.
      beat_d = beat_q;
      wp_d   = wp_q;
      rp_d   = rp_q;
      full_d = full_q;
      if (out_fire) begin
         full_d[rp_q] = 1'b0;
         rp_d         = ~rp_q;
      end
      if (in_fire) begin
         beat_d = beat_q + 3'd1;
         if (beat_q == 3'd7) begin
            full_d[wp_q] = 1'b1;
            wp_d         = ~wp_q;
         end
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         beat_q <= '0;
         wp_q   <= 1'b0;
         rp_q   <= 1'b0;
         full_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         beat_q <= beat_d;
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         full_q <= full_d;
      end
   end

   // Scatter the eight coefficients of an accepted beat into raster positions.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: storage is cleared on reset so an idle output block reads as zero.
         for (int b = 0; b < 2; b++) begin
            for (int p = 0; p < 64; p++) begin
               bank_q[b][p] <= '0;
            end
         end
      end else if (in_fire) begin
         for (int j = 0; j < 8; j++) begin
            bank_q[wp_q][ZZ[{beat_q, j[2:0]}]] <= bus_io.in_data[8*COEF_W-1-COEF_W*j -: COEF_W];
         end
      end
   end

   // Present the read bank as one flat raster-ordered block, position 0 MSB-aligned.
   always_comb begin
      bus_io.out_block = '0;
      for (int p = 0; p < 64; p++) begin
         bus_io.out_block[64*COEF_W-1-COEF_W*p -: COEF_W] = bank_q[rp_q][p];
      end
   end

endmodule

// File: tb/tb_zigzag_block_buffer.sv
// Directed bench for zigzag_block_buffer: reset state, identity block,
// reset mid-block, backpressure, simultaneous pop/complete, and throughput.
module tb_zigzag_block_buffer;

   localparam int W = 8;

   localparam int ZZ [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
   };

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   zigzag_block_buffer_if #(.COEF_W(W)) bus_if ();

   zigzag_block_buffer #(.COEF_W(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus_io (bus_if)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Expected block when beat k carries the value base+k in all eight bytes.
   function automatic logic [511:0] ramp_block(input int base);
      logic [511:0] r;
      r = '0;
      for (int z = 0; z < 64; z++) r[511-8*ZZ[z] -: 8] = 8'(base + z/8);
      return r;
   endfunction

   // Expected block when zigzag index z carries the value z.
   function automatic logic [511:0] ident_block();
      logic [511:0] r;
      r = '0;
      for (int z = 0; z < 64; z++) r[511-8*ZZ[z] -: 8] = 8'(z);
      return r;
   endfunction

   function automatic logic [7:0] byte_at(input logic [511:0] blk, input int p);
      return blk[511-8*p -: 8];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat for one cycle; acc reports whether it was accepted.
   task automatic beat(input logic [63:0] d, output logic acc);
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = d;
      acc = bus_if.in_ready;
      tick();
   endtask

   initial begin
      logic         acc;
      logic [63:0]  d;
      logic [511:0] held;
      int           n_acc;

      reset            = 1'b1;
      bus_if.in_valid  = 1'b0;
      bus_if.in_data   = '0;
      bus_if.out_ready = 1'b0;
      held             = '0;

      // ---------------- reset state ----------------
      #12;
      check("rst_out_valid", bus_if.out_valid, 1'b0);
      check("rst_in_ready",  bus_if.in_ready,  1'b1);
      check("rst_out_block", bus_if.out_block, '0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      check("post_rst_out_valid", bus_if.out_valid, 1'b0);
      check("post_rst_in_ready",  bus_if.in_ready,  1'b1);

      // ---------------- identity block ----------------
      bus_if.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < 8; j++) d[63-8*j -: 8] = 8'(8*k + j);
         beat(d, acc);
         if (k == 6) check("id_no_early_valid", bus_if.out_valid, 1'b0);
      end
      bus_if.in_valid = 1'b0;
      check("id_valid",  bus_if.out_valid, 1'b1);
      check("id_p0",     byte_at(bus_if.out_block, 0),  8'd0);
      check("id_p1",     byte_at(bus_if.out_block, 1),  8'd1);
      check("id_p2",     byte_at(bus_if.out_block, 2),  8'd5);
      check("id_p8",     byte_at(bus_if.out_block, 8),  8'd2);
      check("id_p9",     byte_at(bus_if.out_block, 9),  8'd4);
      check("id_p63",    byte_at(bus_if.out_block, 63), 8'd63);
      check("id_block",  bus_if.out_block, ident_block());
      tick();
      check("id_popped", bus_if.out_valid, 1'b0);

      // ---------------- reset mid-block ----------------
      bus_if.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) beat({8{8'h11}}, acc);
      reset = 1'b1;
      #2;
      check("mid_rst_valid", bus_if.out_valid, 1'b0);
      check("mid_rst_ready", bus_if.in_ready,  1'b1);
      check("mid_rst_block", bus_if.out_block, '0);
      reset = 1'b0;
      for (int k = 0; k < 8; k++) beat({8{8'hAA}}, acc);
      bus_if.in_valid = 1'b0;
      check("mid_valid", bus_if.out_valid, 1'b1);
      check("mid_block", bus_if.out_block, {64{8'hAA}});
      bus_if.out_ready = 1'b1;
      tick();
      check("mid_one_block", bus_if.out_valid, 1'b0);
      bus_if.out_ready = 1'b0;

      // ---------------- backpressure ----------------
      n_acc = 0;
      for (int b = 0; b < 20; b++) begin
         beat({8{8'(b + 1)}}, acc);
         if (acc) n_acc++;
         if (acc && n_acc == 16) check("bp_stall_after16", bus_if.in_ready, 1'b0);
         if (b == 7) held = bus_if.out_block;
      end
      bus_if.in_valid = 1'b0;
      check("bp_accept_cnt",    32'(n_acc), 32'd16);
      check("bp_in_ready_low",  bus_if.in_ready, 1'b0);
      check("bp_valid_held",    bus_if.out_valid, 1'b1);
      check("bp_block_stable",  bus_if.out_block, held);
      check("bp_block_a",       bus_if.out_block, ramp_block(1));
      bus_if.out_ready = 1'b1;
      tick();
      check("bp_valid_b",       bus_if.out_valid, 1'b1);
      check("bp_block_b",       bus_if.out_block, ramp_block(9));
      tick();
      check("bp_drained",       bus_if.out_valid, 1'b0);
      bus_if.out_ready = 1'b0;

      // ---------------- simultaneous pop and completion ----------------
      for (int k = 0; k < 8; k++) beat({8{8'(8'h30 + k)}}, acc);
      for (int k = 0; k < 7; k++) beat({8{8'(8'h50 + k)}}, acc);
      check("sim_c_held",   bus_if.out_block, ramp_block(8'h30));
      check("sim_in_ready", bus_if.in_ready,  1'b1);
      bus_if.out_ready = 1'b1;
      beat({8{8'h56}} + {8{8'h01}}, acc);
      bus_if.in_valid = 1'b0;
      check("sim_no_bubble", bus_if.out_valid, 1'b1);
      check("sim_d_next",    bus_if.out_block, ramp_block(8'h50));
      tick();
      check("sim_drained",   bus_if.out_valid, 1'b0);

      // ---------------- throughput ----------------
      n_acc = 0;
      for (int i = 0; i < 32; i++) begin
         beat({8{8'(i)}}, acc);
         if (acc) n_acc++;
         check($sformatf("tp_valid_%0d", i), bus_if.out_valid, (i % 8 == 7) ? 1'b1 : 1'b0);
         if (i == 7)  check("tp_block_first", bus_if.out_block, ramp_block(0));
         if (i == 31) check("tp_block_last",  bus_if.out_block, ramp_block(24));
      end
      bus_if.in_valid = 1'b0;
      check("tp_ready_cnt", 32'(n_acc), 32'd32);
      tick();
      check("tp_drained", bus_if.out_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
